bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter and transaction sequencer placed in front of the address-decoding Bus. It lets the CPU core (master 0) and a second master such as a DMA or debug engine (master 1) share the single Bus port with round-robin fairness. Each request is latched, driven onto the Bus for a fixed number of access cycles with a single-cycle write strobe, and completed with a one-cycle acknowledge carrying read data.

## Interface
Parameters:
- ACC_CYCLES, default 2: cycles a granted transaction occupies the Bus. Legal range 1..15; 4-bit counter.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- m0_req / m1_req  in  1  request; held high and stable until the matching ack.
- m0_wmem / m1_wmem  in  1  1 = write, 0 = read.
- m0_memc / m1_memc  in  3  access size code, passed through unchanged (0 = byte, 1 = half, 2 = word).
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_ack / m1_ack  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  32  read data; valid while the matching ack is high, held until the next completion.
- bus_A  out  32  address to the Bus.
- bus_Di  out  32  write data to the Bus.
- bus_wmem  out  1  write strobe to the Bus.
- bus_memc  out  3  size code to the Bus.
- bus_Do  in  32  read data from the Bus.
- grant  out  2  one-hot owner of the current transaction; 2'b00 when idle.
- busy  out  1  high in ACCESS and DONE.

## Operation
- State machine states: IDLE, ACCESS, DONE.
- Round-robin pointer `last` is 1 bit and resets to 1, so master 0 wins the first contention.
- IDLE, no req: stay in IDLE. Bus outputs are all 0: address 0 decodes to ROM, which makes an idle read harmless.
- IDLE, any req:
  - Winner is the only requester. If both request, the winner is the master that is not `last`.
  - Latch the winner's addr, wdata, wmem and memc, and set grant.
  - Load the counter with ACC_CYCLES-1 and go to ACCESS.
- ACCESS:
  - bus_A, bus_Di and bus_memc come from the latched registers.
  - bus_wmem = latched wmem on the first ACCESS cycle only. This gives exactly one write, so a UART TX entry is never duplicated.
  - The counter decrements each cycle.
  - When the counter is 0, capture bus_Do into the winner's rdata register and go to DONE.
- DONE:
  - Winner's ack = 1; bus_wmem = 0.
  - `last` is set to the winner's index.
  - Go to IDLE next cycle.
- Write transactions still capture bus_Do; masters ignore the value.
- The non-granted master's rdata holds its previous value.
- Unmapped addresses still complete normally; rdata is whatever the Bus returns (0).

## Timing
- Reset (RESET low at an edge):
  - State goes to IDLE, last = 1, counter = 0.
  - All bus_* outputs, grant, busy, acks and both rdata registers are 0.
  - Reset during ACCESS or DONE aborts the transaction with no ack.
- Request sampled in IDLE at cycle t:
  - ACCESS occupies cycles t+1 .. t+ACC_CYCLES.
  - Ack is high in cycle t+ACC_CYCLES+1.
  - The earliest next grant decision is at t+ACC_CYCLES+2.
- Sustained throughput: one transaction per ACC_CYCLES+2 cycles.
- Requester rule:
  - Deassert req in the cycle after ack, or keep it high to issue a new transaction.
  - Changes to req or payload during ACCESS are ignored, because the transaction was latched.
  - Dropping req mid-transaction is a protocol violation: the transaction still completes and acks.
- Contention: with both req held continuously, grants alternate m0, m1, m0, …
- A single continuous requester is served back-to-back with no bubble beyond the IDLE cycle.
- grant and busy are registered and change only on clock edges.

## Test plan
- After reset with no requests: every output is 0 for 10 cycles.
- ACC_CYCLES = 2, m0 read to 0x10000004 with bus_Do = 0xDEADBEEF:
  - bus_A = 0x10000004 for 2 cycles.
  - m0_ack high exactly 3 cycles after the request is sampled.
  - m0_rdata = 0xDEADBEEF.
- m1 write of 0x00000041 to 0x30000000, memc = 0: bus_wmem high for exactly one cycle with bus_Di = 0x41 and bus_memc = 0; m1_ack follows.
- m0 and m1 both request from reset and hold for 4 transactions:
  - grant sequence is 01, 10, 01, 10.
  - Each ack goes only to the granted master.
- RESET pulled low during ACCESS of an m0 write:
  - no ack is produced and all outputs are 0 the next cycle.
  - after RESET rises, a new m1 request is granted normally.
- ACC_CYCLES = 1, m0 req held continuously: ack every 3 cycles; m1_rdata is unchanged throughout.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two requesting masters, the arbiter and the Bus.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding environment: the requesters plus the Bus read-data return.
interface bus_arbiter_if;
    // Master 0 (CPU core)
    logic        m0_req;
    logic        m0_wmem;
    logic [2:0]  m0_memc;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_ack;
    logic [31:0] m0_rdata;

    // Master 1 (DMA / debug engine)
    logic        m1_req;
    logic        m1_wmem;
    logic [2:0]  m1_memc;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic [31:0] m1_rdata;

    // Shared Bus port
    logic [31:0] bus_A;
    logic [31:0] bus_Di;
    logic        bus_wmem;
    logic [2:0]  bus_memc;
    logic [31:0] bus_Do;

    // Arbitration status
    logic [1:0]  grant;
    logic        busy;

    modport slave (
        input  m0_req, m0_wmem, m0_memc, m0_addr, m0_wdata,
        input  m1_req, m1_wmem, m1_memc, m1_addr, m1_wdata,
        input  bus_Do,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output bus_A, bus_Di, bus_wmem, bus_memc,
        output grant, busy
    );

    modport master (
        output m0_req, m0_wmem, m0_memc, m0_addr, m0_wdata,
        output m1_req, m1_wmem, m1_memc, m1_addr, m1_wdata,
        output bus_Do,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  bus_A, bus_Di, bus_wmem, bus_memc,
        input  grant, busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter and transaction sequencer in front of the Bus.
// A winning request is latched into the Bus output registers, held on the Bus
// for ACC_CYCLES cycles with a single-cycle write strobe, and completed with a
// one-cycle acknowledge that carries the captured read data. All outputs are
// registered.
module bus_arbiter #(
    parameter int unsigned ACC_CYCLES = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    bus_arbiter_if.slave  bus_if
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Counter reload: the ACCESS state ends on the cycle the counter reads 0.
    localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

    // Returns 1 when master 1 wins. Only called with at least one request.
    // Under contention the master that did not own the last transaction wins.
    function automatic logic win_m1(input logic req0, input logic req1,
                                    input logic last);
        logic w;
        if (req0 && req1) begin
            w = ~last;
        end else begin
            w = req1;
        end
        return w;
    endfunction

    // Control state
    state_t      state_r,   state_s;
    logic [3:0]  cnt_r,     cnt_s;
    logic        last_r,    last_s;
    logic [1:0]  grant_r,   grant_s;
    logic        busy_r,    busy_s;

    // Registered Bus outputs (they double as the latched transaction)
    logic [31:0] bus_a_r,    bus_a_s;
    logic [31:0] bus_di_r,   bus_di_s;
    logic        bus_wmem_r, bus_wmem_s;
    logic [2:0]  bus_memc_r, bus_memc_s;

    // Registered completion outputs
    logic        m0_ack_r,   m0_ack_s;
    logic        m1_ack_r,   m1_ack_s;
    logic [31:0] m0_rdata_r, m0_rdata_s;
    logic [31:0] m1_rdata_r, m1_rdata_s;

    logic        win_m1_s;

    // Next-state and next-output logic for the IDLE/ACCESS/DONE sequencer.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        last_s     = last_r;
        grant_s    = grant_r;
        busy_s     = busy_r;
        bus_a_s    = bus_a_r;
        bus_di_s   = bus_di_r;
        bus_memc_s = bus_memc_r;
        bus_wmem_s = 1'b0;            // strobe is only ever raised for one cycle
        m0_ack_s   = 1'b0;
        m1_ack_s   = 1'b0;
        m0_rdata_s = m0_rdata_r;
        m1_rdata_s = m1_rdata_r;
        win_m1_s   = win_m1(bus_if.m0_req, bus_if.m1_req, last_r);

        case (state_r)
            ST_IDLE: begin
                if (bus_if.m0_req || bus_if.m1_req) begin
                    state_s = ST_ACCESS;
                    cnt_s   = CNT_LOAD;
                    busy_s  = 1'b1;
                    if (win_m1_s) begin
                        grant_s    = 2'b10;
                        bus_a_s    = bus_if.m1_addr;
                        bus_di_s   = bus_if.m1_wdata;
                        bus_memc_s = bus_if.m1_memc;
                        bus_wmem_s = bus_if.m1_wmem;
                    end else begin
                        grant_s    = 2'b01;
                        bus_a_s    = bus_if.m0_addr;
                        bus_di_s   = bus_if.m0_wdata;
                        bus_memc_s = bus_if.m0_memc;
                        bus_wmem_s = bus_if.m0_wmem;
                    end
                end else begin
                    // Idle Bus reads address 0 (ROM), which is harmless.
                    grant_s    = 2'b00;
                    busy_s     = 1'b0;
                    bus_a_s    = 32'h0000_0000;
                    bus_di_s   = 32'h0000_0000;
                    bus_memc_s = 3'd0;
                end
            end

            ST_ACCESS: begin
                if (cnt_r == 4'd0) begin
                    // Last access cycle: capture read data for the owner.
                    state_s = ST_DONE;
                    if (grant_r[1]) begin
                        m1_rdata_s = bus_if.bus_Do;
                        m1_ack_s   = 1'b1;
                    end else begin
                        m0_rdata_s = bus_if.bus_Do;
                        m0_ack_s   = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end

            ST_DONE: begin
                // Ack is on the outputs this cycle; release the Bus next.
                state_s    = ST_IDLE;
                last_s     = grant_r[1];
                grant_s    = 2'b00;
                busy_s     = 1'b0;
                bus_a_s    = 32'h0000_0000;
                bus_di_s   = 32'h0000_0000;
                bus_memc_s = 3'd0;
            end

            default: begin
                state_s    = ST_IDLE;
                cnt_s      = 4'd0;
                grant_s    = 2'b00;
                busy_s     = 1'b0;
                bus_a_s    = 32'h0000_0000;
                bus_di_s   = 32'h0000_0000;
                bus_memc_s = 3'd0;
            end
        endcase
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            last_r  <= 1'b1;          // master 0 wins the first contention
            grant_r <= 2'b00;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            last_r  <= last_s;
            grant_r <= grant_s;
            busy_r  <= busy_s;
        end
    end

    // Bus and completion output registers; reset aborts without an ack.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            bus_a_r    <= 32'h0000_0000;
            bus_di_r   <= 32'h0000_0000;
            bus_wmem_r <= 1'b0;
            bus_memc_r <= 3'd0;
            m0_ack_r   <= 1'b0;
            m1_ack_r   <= 1'b0;
            m0_rdata_r <= 32'h0000_0000;
            m1_rdata_r <= 32'h0000_0000;
        end else begin
            bus_a_r    <= bus_a_s;
            bus_di_r   <= bus_di_s;
            bus_wmem_r <= bus_wmem_s;
            bus_memc_r <= bus_memc_s;
            m0_ack_r   <= m0_ack_s;
            m1_ack_r   <= m1_ack_s;
            m0_rdata_r <= m0_rdata_s;
            m1_rdata_r <= m1_rdata_s;
        end
    end

    assign bus_if.bus_A    = bus_a_r;
    assign bus_if.bus_Di   = bus_di_r;
    assign bus_if.bus_wmem = bus_wmem_r;
    assign bus_if.bus_memc = bus_memc_r;
    assign bus_if.m0_ack   = m0_ack_r;
    assign bus_if.m1_ack   = m1_ack_r;
    assign bus_if.m0_rdata = m0_rdata_r;
    assign bus_if.m1_rdata = m1_rdata_r;
    assign bus_if.grant    = grant_r;
    assign bus_if.busy     = busy_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed, scoreboard-based bench for bus_arbiter. Two instances are used:
// one with ACC_CYCLES = 2 for most scenarios and one with ACC_CYCLES = 1 for
// the back-to-back single-requester case.
module tb_bus_arbiter;

    localparam int          ACC2 = 2;
    localparam int          ACC1 = 1;
    localparam logic [31:0] KEY  = 32'hC3C3_3C3C;   // Bus model: Do = A ^ KEY

    typedef struct {
        int          m;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic        CLK      = 1'b0;
    logic        RESET    = 1'b0;
    logic        model_en = 1'b1;
    logic [31:0] bus_do_fix = 32'h0000_0000;

    bus_arbiter_if ifc2 ();
    bus_arbiter_if ifc1 ();

    assign ifc2.bus_Do = model_en ? (ifc2.bus_A ^ KEY) : bus_do_fix;
    assign ifc1.bus_Do = ifc1.bus_A ^ KEY;

    bus_arbiter #(.ACC_CYCLES(ACC2)) dut2 (.CLK(CLK), .RESET(RESET), .bus_if(ifc2.slave));
    bus_arbiter #(.ACC_CYCLES(ACC1)) dut1 (.CLK(CLK), .RESET(RESET), .bus_if(ifc1.slave));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive2(input int m, input logic rq, input logic wr, input logic [2:0] mc,
                          input logic [31:0] a, input logic [31:0] wd);
        if (m == 0) begin
            ifc2.m0_req = rq; ifc2.m0_wmem = wr; ifc2.m0_memc = mc;
            ifc2.m0_addr = a; ifc2.m0_wdata = wd;
        end else begin
            ifc2.m1_req = rq; ifc2.m1_wmem = wr; ifc2.m1_memc = mc;
            ifc2.m1_addr = a; ifc2.m1_wdata = wd;
        end
    endtask

    // One complete transaction on the ACC_CYCLES=2 instance; starts just
    // after a rising edge with the arbiter idle, ends just after the edge
    // following the ack with the request dropped.
    task automatic txn(input int m, input logic wr, input logic [2:0] mc,
                       input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] other_rd;
        int          cyc  = 0;
        int          nw   = 0;
        int          nacc = 0;
        bit          seen = 1'b0;
        logic        my_ack;
        exp_t        e;
        drive2(m, 1'b1, wr, mc, a, wd);
        sb.push_back('{m, (model_en ? (a ^ KEY) : bus_do_fix)});
        other_rd = (m == 0) ? ifc2.m1_rdata : ifc2.m0_rdata;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (ifc2.bus_wmem) begin
                nw++;
                check("wr_data", ifc2.bus_Di, wd);
                check("wr_memc", {29'd0, ifc2.bus_memc}, {29'd0, mc});
            end
            if (ifc2.busy && !ifc2.m0_ack && !ifc2.m1_ack && ifc2.bus_A == a) nacc++;
            my_ack = (m == 0) ? ifc2.m0_ack : ifc2.m1_ack;
            if (my_ack) begin
                cyc  = i;
                seen = 1'b1;
                break;
            end
        end
        check("ack_seen", {31'd0, seen}, 32'd1);
        check("ack_latency", cyc - 1, ACC2 + 1);
        check("ack_other", {31'd0, (m == 0) ? ifc2.m1_ack : ifc2.m0_ack}, 32'd0);
        check("grant", {30'd0, ifc2.grant}, (m == 0) ? 32'd1 : 32'd2);
        e = sb.pop_front();
        check("rdata", (m == 0) ? ifc2.m0_rdata : ifc2.m1_rdata, e.rd);
        check("other_rdata_hold", (m == 0) ? ifc2.m1_rdata : ifc2.m0_rdata, other_rd);
        check("wstrobe_count", nw, wr ? 32'd1 : 32'd0);
        check("access_cycles", nacc, ACC2);
        @(posedge CLK); #1;
        drive2(m, 1'b0, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_0000);
    endtask

    initial begin
        exp_t e;
        bit   seen;
        int   ncyc;
        int   last_ack;

        drive2(0, 1'b0, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_0000);
        drive2(1, 1'b0, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_0000);
        ifc1.m0_req = 1'b0; ifc1.m0_wmem = 1'b0; ifc1.m0_memc = 3'd0;
        ifc1.m0_addr = 32'h0000_0000; ifc1.m0_wdata = 32'h0000_0000;
        ifc1.m1_req = 1'b0; ifc1.m1_wmem = 1'b0; ifc1.m1_memc = 3'd0;
        ifc1.m1_addr = 32'h0000_0000; ifc1.m1_wdata = 32'h0000_0000;

        // Reset, then 10 idle cycles with every output at 0
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("idle2_data", ifc2.bus_A | ifc2.bus_Di | ifc2.m0_rdata | ifc2.m1_rdata, 32'd0);
            check("idle2_ctl", {23'd0, ifc2.bus_wmem, ifc2.bus_memc, ifc2.grant, ifc2.busy,
                                ifc2.m0_ack, ifc2.m1_ack}, 32'd0);
            check("idle1_data", ifc1.bus_A | ifc1.bus_Di | ifc1.m0_rdata | ifc1.m1_rdata, 32'd0);
            check("idle1_ctl", {23'd0, ifc1.bus_wmem, ifc1.bus_memc, ifc1.grant, ifc1.busy,
                                ifc1.m0_ack, ifc1.m1_ack}, 32'd0);
        end

        // m0 word read from 0x10000004 with a fixed Bus return value
        @(posedge CLK); #1;
        model_en   = 1'b0;
        bus_do_fix = 32'hDEAD_BEEF;
        txn(0, 1'b0, 3'd2, 32'h1000_0004, 32'h0000_0000);

        // m1 byte write of 0x41 to 0x30000000 (UART TX)
        model_en = 1'b1;
        txn(1, 1'b1, 3'd0, 32'h3000_0000, 32'h0000_0041);

        // Contention from reset: grants alternate 01,10,01,10
        @(posedge CLK); #1 RESET = 1'b0;
        @(posedge CLK); #1 RESET = 1'b1;
        drive2(0, 1'b1, 1'b0, 3'd2, 32'h0000_1000, 32'h0000_0000);
        drive2(1, 1'b1, 1'b0, 3'd2, 32'h2000_0010, 32'h0000_0000);
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{k % 2, ((k % 2 == 0) ? 32'h0000_1000 : 32'h2000_0010) ^ KEY});
        end
        ncyc = 0;
        last_ack = 0;
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge CLK);
                ncyc++;
                if (ifc2.m0_ack || ifc2.m1_ack) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("cont_ack_seen", {31'd0, seen}, 32'd1);
            e = sb.pop_front();
            check("cont_grant", {30'd0, ifc2.grant}, (e.m == 0) ? 32'd1 : 32'd2);
            check("cont_ack_onehot", {30'd0, ifc2.m1_ack, ifc2.m0_ack}, (e.m == 0) ? 32'd1 : 32'd2);
            check("cont_rdata", (e.m == 0) ? ifc2.m0_rdata : ifc2.m1_rdata, e.rd);
            if (k > 0) check("cont_spacing", ncyc - last_ack, ACC2 + 2);
            last_ack = ncyc;
        end
        @(posedge CLK); #1;
        drive2(0, 1'b0, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_0000);
        drive2(1, 1'b0, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_0000);
        @(negedge CLK);
        check("cont_release", {30'd0, ifc2.grant}, 32'd0);

        // Reset during ACCESS of an m0 write aborts it without an ack
        @(posedge CLK); #1;
        drive2(0, 1'b1, 1'b1, 3'd0, 32'h3000_0000, 32'h0000_0055);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (ifc2.busy) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_busy_seen", {31'd0, seen}, 32'd1);
        check("abort_first_strobe", {31'd0, ifc2.bus_wmem}, 32'd1);
        RESET = 1'b0;
        drive2(0, 1'b0, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_0000);
        @(negedge CLK);
        check("abort_data_zero", ifc2.bus_A | ifc2.bus_Di | ifc2.m0_rdata | ifc2.m1_rdata, 32'd0);
        check("abort_ctl_zero", {23'd0, ifc2.bus_wmem, ifc2.bus_memc, ifc2.grant, ifc2.busy,
                                 ifc2.m0_ack, ifc2.m1_ack}, 32'd0);
        RESET = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("abort_no_ack", {29'd0, ifc2.m1_ack, ifc2.m0_ack, ifc2.busy}, 32'd0);
        end
        @(posedge CLK); #1;
        txn(1, 1'b0, 3'd2, 32'h2000_0040, 32'h0000_0000);

        // ACC_CYCLES = 1, m0 held continuously: ack every 3 cycles
        ifc1.m0_req  = 1'b1;
        ifc1.m0_addr = 32'h0000_0100;
        ifc1.m0_memc = 3'd2;
        ncyc = 0;
        last_ack = 0;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{0, 32'h0000_0100 ^ KEY});
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge CLK);
                ncyc++;
                if (ifc1.m0_ack) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("acc1_ack_seen", {31'd0, seen}, 32'd1);
            e = sb.pop_front();
            check("acc1_rdata", ifc1.m0_rdata, e.rd);
            check("acc1_m1_rdata", ifc1.m1_rdata, 32'd0);
            check("acc1_m1_ack", {31'd0, ifc1.m1_ack}, 32'd0);
            if (k > 0) check("acc1_spacing", ncyc - last_ack, ACC1 + 2);
            last_ack = ncyc;
        end
        @(posedge CLK); #1 ifc1.m0_req = 1'b0;
        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
